// File: rtl/axi_rom_read_arbiter.sv
// axi_rom_read_arbiter
// Shares one AXI4-Lite read-only boot ROM port between two requesters
// (s0 = CPU fetch, s1 = debug/loader). Round-robin on ties, one outstanding
// transaction at a time. Reads outside the ROM window or not word aligned are
// answered locally with SLVERR and never reach the ROM.
module axi_rom_read_arbiter #(
  parameter logic [31:0] ROM_BASE  = 32'h0000_0000,
  parameter int unsigned ROM_WORDS = 128,
  parameter logic [31:0] ERR_DATA  = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s0_arvalid,
  output logic        s0_arready,
  input  logic [31:0] s0_araddr,
  output logic        s0_rvalid,
  input  logic        s0_rready,
  output logic [31:0] s0_rdata,
  output logic [1:0]  s0_rresp,
  input  logic        s1_arvalid,
  output logic        s1_arready,
  input  logic [31:0] s1_araddr,
  output logic        s1_rvalid,
  input  logic        s1_rready,
  output logic [31:0] s1_rdata,
  output logic [1:0]  s1_rresp,
  output logic        rom_arvalid,
  input  logic        rom_arready,
  output logic [31:0] rom_araddr,
  input  logic        rom_rvalid,
  output logic        rom_rready,
  input  logic [31:0] rom_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ROM_AR = 2'd1,
    ROM_R  = 2'd2,
    ERR_R  = 2'd3
  } state_t;

  state_t      state_r;
  state_t      state_nxt_s;
  logic        gnt_r;
  logic        last_r;
  logic [31:0] addr_r;
  logic        req_s;
  logic        sel_s;
  logic [31:0] sel_addr_s;
  logic        g_rready_s;
  logic        done_s;

  // Window and alignment check in 33-bit arithmetic so nothing wraps past 2^32.
  function automatic logic addr_legal(input logic [31:0] addr);
    logic [32:0] off;
    off = {1'b0, addr} - {1'b0, ROM_BASE};
    return (addr[1:0] == 2'b00) &&
           ({1'b0, addr} >= {1'b0, ROM_BASE}) &&
           ({2'b00, off[32:2]} < 33'(ROM_WORDS));
  endfunction

  // Requester selection: a lone requester wins, a tie goes to the one not served last.
  always_comb begin
    req_s = s0_arvalid | s1_arvalid;
    if (s0_arvalid && s1_arvalid) begin
      sel_s = ~last_r;
    end else begin
      sel_s = s1_arvalid;
    end
    sel_addr_s = sel_s ? s1_araddr : s0_araddr;
    g_rready_s = gnt_r ? s1_rready : s0_rready;
  end

  // Next-state and output decode; every output starts from its quiet value.
  always_comb begin
    state_nxt_s = state_r;
    done_s      = 1'b0;
    s0_arready  = 1'b0;
    s0_rvalid   = 1'b0;
    s0_rdata    = 32'd0;
    s0_rresp    = 2'b00;
    s1_arready  = 1'b0;
    s1_rvalid   = 1'b0;
    s1_rdata    = 32'd0;
    s1_rresp    = 2'b00;
    rom_arvalid = 1'b0;
    rom_araddr  = 32'd0;
    rom_rready  = 1'b0;
    case (state_r)
      IDLE: begin
        // rst_n gating keeps arready low while reset is held
        if (req_s && rst_n) begin
          if (sel_s) begin
            s1_arready = 1'b1;
          end else begin
            s0_arready = 1'b1;
          end
          state_nxt_s = addr_legal(sel_addr_s) ? ROM_AR : ERR_R;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ROM_AR: begin
        rom_arvalid = 1'b1;
        rom_araddr  = addr_r - ROM_BASE;
        if (rom_arready) begin
          state_nxt_s = ROM_R;
        end else begin
          state_nxt_s = ROM_AR;
        end
      end
      ROM_R: begin
        rom_rready = g_rready_s;
        if (gnt_r) begin
          s1_rvalid = rom_rvalid;
          s1_rdata  = rom_rvalid ? rom_rdata : 32'd0;
        end else begin
          s0_rvalid = rom_rvalid;
          s0_rdata  = rom_rvalid ? rom_rdata : 32'd0;
        end
        if (rom_rvalid && g_rready_s) begin
          done_s      = 1'b1;
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = ROM_R;
        end
      end
      ERR_R: begin
        if (gnt_r) begin
          s1_rvalid = 1'b1;
          s1_rdata  = ERR_DATA;
          s1_rresp  = 2'b10;
        end else begin
          s0_rvalid = 1'b1;
          s0_rdata  = ERR_DATA;
          s0_rresp  = 2'b10;
        end
        if (g_rready_s) begin
          done_s      = 1'b1;
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = ERR_R;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State, grant, captured address and round-robin history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      gnt_r   <= 1'b0;
      last_r  <= 1'b1;
      addr_r  <= 32'd0;
    end else begin
      state_r <= state_nxt_s;
      if ((state_r == IDLE) && req_s) begin
        gnt_r  <= sel_s;
        addr_r <= sel_addr_s;
      end
      if (done_s) begin
        last_r <= gnt_r;
      end
    end
  end

  // Busy flag follows the state register directly.
  always_comb begin
    busy = (state_r != IDLE);
  end

endmodule

// File: tb/tb_axi_rom_read_arbiter.sv
// Bench for axi_rom_read_arbiter: directed steps plus randomized request
// pairs, checked against a transaction-level model of arbitration order,
// window legality and ROM contents kept in this module.
module tb_axi_rom_read_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        s0_arvalid, s0_arready, s0_rvalid, s0_rready;
  logic [31:0] s0_araddr, s0_rdata;
  logic [1:0]  s0_rresp;
  logic        s1_arvalid, s1_arready, s1_rvalid, s1_rready;
  logic [31:0] s1_araddr, s1_rdata;
  logic [1:0]  s1_rresp;
  logic        rom_arvalid, rom_arready, rom_rvalid, rom_rready, busy;
  logic [31:0] rom_araddr, rom_rdata;

  logic        b_s0_arvalid, b_s0_arready, b_s0_rvalid, b_s0_rready;
  logic [31:0] b_s0_araddr, b_s0_rdata;
  logic [1:0]  b_s0_rresp;
  logic        b_s1_arvalid, b_s1_arready, b_s1_rvalid, b_s1_rready;
  logic [31:0] b_s1_araddr, b_s1_rdata;
  logic [1:0]  b_s1_rresp;
  logic        b_rom_arvalid, b_rom_arready, b_rom_rvalid, b_rom_rready, b_busy;
  logic [31:0] b_rom_araddr, b_rom_rdata;

  int          errors = 0;
  int          checks = 0;
  int          rom_ar_count = 0;
  int          cnt_before;
  logic        last_m = 1'b1;
  logic [31:0] mem [0:127];

  axi_rom_read_arbiter u_dut (
    .clk(clk), .rst_n(rst_n),
    .s0_arvalid(s0_arvalid), .s0_arready(s0_arready), .s0_araddr(s0_araddr),
    .s0_rvalid(s0_rvalid), .s0_rready(s0_rready), .s0_rdata(s0_rdata), .s0_rresp(s0_rresp),
    .s1_arvalid(s1_arvalid), .s1_arready(s1_arready), .s1_araddr(s1_araddr),
    .s1_rvalid(s1_rvalid), .s1_rready(s1_rready), .s1_rdata(s1_rdata), .s1_rresp(s1_rresp),
    .rom_arvalid(rom_arvalid), .rom_arready(rom_arready), .rom_araddr(rom_araddr),
    .rom_rvalid(rom_rvalid), .rom_rready(rom_rready), .rom_rdata(rom_rdata),
    .busy(busy)
  );

  axi_rom_read_arbiter #(.ROM_BASE(32'h0000_1000)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .s0_arvalid(b_s0_arvalid), .s0_arready(b_s0_arready), .s0_araddr(b_s0_araddr),
    .s0_rvalid(b_s0_rvalid), .s0_rready(b_s0_rready), .s0_rdata(b_s0_rdata), .s0_rresp(b_s0_rresp),
    .s1_arvalid(b_s1_arvalid), .s1_arready(b_s1_arready), .s1_araddr(b_s1_araddr),
    .s1_rvalid(b_s1_rvalid), .s1_rready(b_s1_rready), .s1_rdata(b_s1_rdata), .s1_rresp(b_s1_rresp),
    .rom_arvalid(b_rom_arvalid), .rom_arready(b_rom_arready), .rom_araddr(b_rom_araddr),
    .rom_rvalid(b_rom_rvalid), .rom_rready(b_rom_rready), .rom_rdata(b_rom_rdata),
    .busy(b_busy)
  );

  // ROM model: accepts an address at once, returns data on the next cycle.
  assign rom_arready = 1'b1;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_rvalid <= 1'b0;
      rom_rdata  <= 32'd0;
    end else begin
      if (rom_rvalid && rom_rready) begin
        rom_rvalid <= 1'b0;
        rom_rdata  <= 32'd0;
      end
      if (rom_arvalid && rom_arready) begin
        rom_rvalid   <= 1'b1;
        rom_rdata    <= mem[rom_araddr[8:2]];
        rom_ar_count <= rom_ar_count + 1;
      end
    end
  end

  // ROM model for the relocated instance: data is the offset xor a tag.
  assign b_rom_arready = 1'b1;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_rom_rvalid <= 1'b0;
      b_rom_rdata  <= 32'd0;
    end else begin
      if (b_rom_rvalid && b_rom_rready) begin
        b_rom_rvalid <= 1'b0;
      end
      if (b_rom_arvalid && b_rom_arready) begin
        b_rom_rvalid <= 1'b1;
        b_rom_rdata  <= b_rom_araddr ^ 32'hA5A5_0000;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Window at base 0 holds 128 words.
  function automatic logic legal_a(input logic [31:0] a);
    return (a % 32'd4 == 32'd0) && (a / 32'd4 < 32'd128);
  endfunction

  function automatic logic [31:0] exp_data(input logic [31:0] a);
    return legal_a(a) ? mem[a[8:2]] : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] rand_addr();
    int unsigned k;
    logic [31:0] a;
    k = $urandom_range(0, 3);
    a = 32'($urandom_range(0, 127) * 4);
    if (k == 2) a = a + 32'h0000_0200;
    else if (k == 3) a = a + 32'($urandom_range(1, 3));
    return a;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_rom_arvalid", rom_arvalid, 1'b0);
    chk("rst_rom_araddr", rom_araddr, 32'd0);
    chk1("rst_rom_rready", rom_rready, 1'b0);
    chk1("rst_s0_rvalid", s0_rvalid, 1'b0);
    chk("rst_s1_rdata", s1_rdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    last_m = 1'b1;
  endtask

  // Issue one or two simultaneous requests and follow them to completion.
  task automatic do_pair(input logic v0, input logic [31:0] a0, input logic v1, input logic [31:0] a1);
    int   order[$];
    logic d0, d1, acc0, acc1;
    int   n;
    d0 = ~v0;
    d1 = ~v1;
    n  = 0;
    @(negedge clk);
    s0_arvalid = v0; s0_araddr = a0;
    s1_arvalid = v1; s1_araddr = a1;
    while (!(d0 && d1) && n < 40) begin
      #1;
      acc0 = s0_arvalid & s0_arready;
      acc1 = s1_arvalid & s1_arready;
      chk1("pair_excl", acc0 & acc1, 1'b0);
      if (acc0) order.push_back(0);
      if (acc1) order.push_back(1);
      if (s0_rvalid && !d0) begin
        chk("pair_s0_rdata", s0_rdata, exp_data(a0));
        chk("pair_s0_rresp", 32'(s0_rresp), legal_a(a0) ? 32'd0 : 32'd2);
        d0 = 1'b1;
      end
      if (s1_rvalid && !d1) begin
        chk("pair_s1_rdata", s1_rdata, exp_data(a1));
        chk("pair_s1_rresp", 32'(s1_rresp), legal_a(a1) ? 32'd0 : 32'd2);
        d1 = 1'b1;
      end
      @(posedge clk);
      #1;
      if (acc0) s0_arvalid = 1'b0;
      if (acc1) s1_arvalid = 1'b0;
      @(negedge clk);
      n++;
    end
    chk("pair_done", {30'd0, d0, d1}, 32'd3);
    s0_arvalid = 1'b0;
    s1_arvalid = 1'b0;
    if (v0 && v1) begin
      chk("pair_order_n", 32'(order.size()), 32'd2);
      chk("pair_first", (order.size() > 0) ? 32'(order[0]) : 32'd9, last_m ? 32'd0 : 32'd1);
      // loser is served second, so the history bit ends up unchanged
    end else begin
      last_m = v1;
    end
  endtask

  // Single s1 read that must be answered locally with SLVERR.
  task automatic err_read(input logic [31:0] a);
    @(negedge clk);
    s1_arvalid = 1'b1; s1_araddr = a;
    #1;
    chk1("err_arready", s1_arready, 1'b1);
    @(posedge clk);
    #1;
    s1_arvalid = 1'b0;
    @(negedge clk);
    chk1("err_rvalid", s1_rvalid, 1'b1);
    chk("err_rdata", s1_rdata, 32'hDEAD_BEEF);
    chk("err_rresp", 32'(s1_rresp), 32'd2);
    chk1("err_rom_arvalid", rom_arvalid, 1'b0);
    chk("err_s0_rdata", s0_rdata, 32'd0);
    @(negedge clk);
    chk1("err_idle", busy, 1'b0);
    last_m = 1'b1;
  endtask

  initial begin
    s0_arvalid = 1'b0; s0_araddr = 32'd0; s0_rready = 1'b1;
    s1_arvalid = 1'b0; s1_araddr = 32'd0; s1_rready = 1'b1;
    b_s0_arvalid = 1'b0; b_s0_araddr = 32'd0; b_s0_rready = 1'b1;
    b_s1_arvalid = 1'b0; b_s1_araddr = 32'd0; b_s1_rready = 1'b1;
    for (int i = 0; i < 128; i++) mem[i] = $urandom();
    mem[0] = 32'h0000_0093;
    do_reset();

    // Basic s0 fetch with cycle-exact latency.
    @(negedge clk);
    s0_arvalid = 1'b1; s0_araddr = 32'h0000_0000;
    #1;
    chk1("t1_s0_arready", s0_arready, 1'b1);
    chk1("t1_s1_arready", s1_arready, 1'b0);
    @(posedge clk);
    #1;
    s0_arvalid = 1'b0;
    @(negedge clk);
    chk1("t1_rom_arvalid", rom_arvalid, 1'b1);
    chk("t1_rom_araddr", rom_araddr, 32'd0);
    chk1("t1_busy", busy, 1'b1);
    chk1("t1_rvalid_c1", s0_rvalid, 1'b0);
    @(negedge clk);
    chk1("t1_rvalid_c2", s0_rvalid, 1'b1);
    chk("t1_rdata", s0_rdata, 32'h0000_0093);
    chk("t1_rresp", 32'(s0_rresp), 32'd0);
    chk1("t1_s1_rvalid", s1_rvalid, 1'b0);
    chk("t1_s1_rdata", s1_rdata, 32'd0);
    @(negedge clk);
    chk1("t1_idle", busy, 1'b0);
    last_m = 1'b0;

    // Ties after reset: order 0,1,0,1.
    do_reset();
    do_pair(1'b1, 32'h4, 1'b1, 32'h8);
    do_pair(1'b1, 32'hC, 1'b1, 32'h10);

    // Local errors never touch the ROM.
    cnt_before = rom_ar_count;
    err_read(32'h0000_0200);
    err_read(32'h0000_0006);
    chk("t3_rom_untouched", 32'(rom_ar_count), 32'(cnt_before));

    // Back-pressure on s0 while s1 waits.
    @(negedge clk);
    s0_rready = 1'b0; s0_arvalid = 1'b1; s0_araddr = 32'h10;
    @(posedge clk);
    #1;
    s0_arvalid = 1'b0;
    @(negedge clk);
    s1_arvalid = 1'b1; s1_araddr = 32'h14;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk1("bp_s0_rvalid", s0_rvalid, 1'b1);
      chk("bp_s0_rdata", s0_rdata, mem[4]);
      chk1("bp_s1_arready", s1_arready, 1'b0);
      chk1("bp_rom_rready", rom_rready, 1'b0);
      @(negedge clk);
    end
    s0_rready = 1'b1;
    #1;
    chk1("bp_rom_rready_hs", rom_rready, 1'b1);
    chk1("bp_s1_arready_hs", s1_arready, 1'b0);
    @(negedge clk);
    chk1("bp_s1_accept", s1_arready, 1'b1);
    chk1("bp_s0_rvalid_off", s0_rvalid, 1'b0);
    chk("bp_s0_rdata_off", s0_rdata, 32'd0);
    @(posedge clk);
    #1;
    s1_arvalid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk1("bp_s1_rvalid", s1_rvalid, 1'b1);
    chk("bp_s1_rdata", s1_rdata, mem[5]);
    @(negedge clk);
    last_m = 1'b1;

    // Asynchronous reset in the middle of ROM_AR.
    s0_arvalid = 1'b1; s0_araddr = 32'h20;
    @(posedge clk);
    #1;
    s0_arvalid = 1'b0;
    #2;
    chk1("ar_rst_pre_arvalid", rom_arvalid, 1'b1);
    rst_n = 1'b0;
    #1;
    chk1("ar_rst_arvalid", rom_arvalid, 1'b0);
    chk1("ar_rst_busy", busy, 1'b0);
    chk1("ar_rst_s0_rvalid", s0_rvalid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    last_m = 1'b1;
    do_pair(1'b1, 32'h24, 1'b1, 32'h28);

    // Window edges: last word, top-of-space wrap, first word past the end.
    do_pair(1'b1, 32'h1FC, 1'b0, 32'd0);
    do_pair(1'b1, 32'hFFFF_FFFC, 1'b1, 32'h200);

    // Randomized request pairs.
    for (int r = 0; r < 24; r++) begin
      logic rv0, rv1;
      rv0 = 1'($urandom_range(0, 1));
      rv1 = rv0 ? 1'($urandom_range(0, 1)) : 1'b1;
      do_pair(rv0, rand_addr(), rv1, rand_addr());
    end

    // Relocated window at 0x1000.
    @(negedge clk);
    b_s0_arvalid = 1'b1; b_s0_araddr = 32'h0000_1010;
    #1;
    chk1("b_arready", b_s0_arready, 1'b1);
    @(posedge clk);
    #1;
    b_s0_arvalid = 1'b0;
    @(negedge clk);
    chk1("b_rom_arvalid", b_rom_arvalid, 1'b1);
    chk("b_rom_araddr", b_rom_araddr, 32'h0000_0010);
    @(negedge clk);
    chk1("b_rvalid", b_s0_rvalid, 1'b1);
    chk("b_rdata", b_s0_rdata, 32'hA5A5_0010);
    chk("b_rresp", 32'(b_s0_rresp), 32'd0);
    @(negedge clk);
    b_s0_arvalid = 1'b1; b_s0_araddr = 32'h0000_0FFC;
    @(posedge clk);
    #1;
    b_s0_arvalid = 1'b0;
    @(negedge clk);
    chk1("b_err_rvalid", b_s0_rvalid, 1'b1);
    chk("b_err_rdata", b_s0_rdata, 32'hDEAD_BEEF);
    chk("b_err_rresp", 32'(b_s0_rresp), 32'd2);
    chk1("b_err_rom_arvalid", b_rom_arvalid, 1'b0);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
